// File: rtl/game_timer_pkg.sv
// ============================================================================
// game_timer_pkg : shared types and constants for the game timer stage
// Rev 1.0
// ============================================================================
`default_nettype none

package game_timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DEFAULT_CFG10S = 4'd0;
  localparam bcd_t MAX_CFG10S     = 4'd9;

  // Two-bit half-second counts indexed by speed; speed 0 behaves as speed 1.
  localparam logic [7:0] SPEED_TO_HALFSECS = {2'd3, 2'd2, 2'd1, 2'd1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } cd_state_e;

  function automatic logic [1:0] halfsecs_of(input logic [1:0] speed);
    return SPEED_TO_HALFSECS[{speed, 1'b0} +: 2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_timer_control_halfsec_interval.sv
// ============================================================================
// halfsec_interval : one-shot interval of N half-seconds, pulses once per arm
// Rev 1.0
// ============================================================================
`default_nettype none

module halfsec_interval
  import game_timer_pkg::*;
#(
  parameter int HALF_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] halfsecs,
  output logic       done_pulse
);

  localparam int CNT_W = $clog2(3 * HALF_CYCLES + 1);

  logic             armed_q;
  logic             done_q;
  logic             pulse_q;
  logic [1:0]       mult_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]       mult_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] target_d;

  // The first enabled cycle already counts, so the pulse lands on cycle N*HALF.
  always_comb begin
    mult_d   = armed_q ? mult_q : halfsecs_of(halfsecs);
    cnt_d    = armed_q ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
    target_d = CNT_W'(mult_d) * CNT_W'(HALF_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
      mult_q  <= 2'd0;
      cnt_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      mult_q  <= mult_d;
      pulse_q <= 1'b0;
      if (!done_q) begin
        cnt_q <= cnt_d;
        if (cnt_d == target_d) begin
          pulse_q <= 1'b1;
          done_q  <= 1'b1;
        end
      end
    end
  end

  assign done_pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/game_timer_control.sv
// ============================================================================
// game_timer_control : configurable game countdown plus flash/gap interval timers
// Rev 1.0
// ============================================================================
`default_nettype none

module game_timer_control
  import game_timer_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int WAIT_HALF_SECS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ReConfig,
  input  logic       incrementTime10,
  input  logic       decrementTime10,
  input  logic       timerEnable,
  input  logic [1:0] speedMultiplier,
  input  logic       timerDisplayEnable,
  input  logic       timerWaitEnable,
  output logic       timeout,
  output logic       timeoutDisplay,
  output logic       timeoutWait,
  output logic [3:0] time10s,
  output logic [3:0] time1s
);

  localparam int         SEC_CYCLES    = CLK_HZ;
  localparam int         HALF_CYCLES   = CLK_HZ / 2;
  localparam int         PRESC_W       = $clog2(SEC_CYCLES + 1);
  localparam logic [1:0] WAIT_HALFSECS = 2'(WAIT_HALF_SECS);

  cd_state_e          state_q;
  bcd_t               cfg10s_q;
  bcd_t               cfg10s_d;
  bcd_t               tens_q;
  bcd_t               ones_q;
  bcd_t               tens_dec;
  bcd_t               ones_dec;
  logic [PRESC_W-1:0] presc_q;
  logic               timeout_q;
  logic               edit_ok;

  assign edit_ok = ReConfig && !timerEnable && (incrementTime10 ^ decrementTime10);

  always_comb begin
    cfg10s_d = cfg10s_q;
    if (edit_ok) begin
      if (incrementTime10 && (cfg10s_q < MAX_CFG10S)) begin
        cfg10s_d = cfg10s_q + 4'd1;
      end else if (decrementTime10 && (cfg10s_q > 4'd0)) begin
        cfg10s_d = cfg10s_q - 4'd1;
      end
    end
  end

  always_comb begin
    ones_dec = (ones_q == 4'd0) ? 4'd9 : (ones_q - 4'd1);
    tens_dec = (ones_q == 4'd0) ? (tens_q - 4'd1) : tens_q;
  end

  // Prescaler rests at 0 in IDLE, so the first enabled cycle is count 1 of RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cfg10s_q  <= DEFAULT_CFG10S;
      tens_q    <= DEFAULT_CFG10S;
      ones_q    <= 4'd9;
      presc_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      cfg10s_q <= cfg10s_d;
      if (!timerEnable) begin
        state_q   <= ST_IDLE;
        tens_q    <= cfg10s_d;
        ones_q    <= 4'd9;
        presc_q   <= '0;
        timeout_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_RUN: begin
            state_q <= ST_RUN;
            if (presc_q == PRESC_W'(SEC_CYCLES - 1)) begin
              presc_q <= '0;
              tens_q  <= tens_dec;
              ones_q  <= ones_dec;
              if ((tens_dec == 4'd0) && (ones_dec == 4'd0)) begin
                state_q   <= ST_EXPIRED;
                timeout_q <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + PRESC_W'(1);
            end
          end
          ST_EXPIRED: begin
            state_q   <= ST_EXPIRED;
            timeout_q <= 1'b1;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign timeout = timeout_q;
  assign time10s = tens_q;
  assign time1s  = ones_q;

  halfsec_interval #(
    .HALF_CYCLES (HALF_CYCLES)
  ) u_flash (
    .clk        (clk),
    .rst        (rst),
    .enable     (timerDisplayEnable),
    .halfsecs   (speedMultiplier),
    .done_pulse (timeoutDisplay)
  );

  halfsec_interval #(
    .HALF_CYCLES (HALF_CYCLES)
  ) u_gap (
    .clk        (clk),
    .rst        (rst),
    .enable     (timerWaitEnable),
    .halfsecs   (WAIT_HALFSECS),
    .done_pulse (timeoutWait)
  );

endmodule

`default_nettype wire

// File: tb/tb_game_timer_control.sv
// ============================================================================
// tb_game_timer_control : directed and random checks against a time-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_game_timer_control;

  localparam int CLK_HZ         = 8;
  localparam int WAIT_HALF_SECS = 1;
  localparam int SEC            = CLK_HZ;
  localparam int HALF           = CLK_HZ / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       ReConfig;
  logic       incrementTime10;
  logic       decrementTime10;
  logic       timerEnable;
  logic [1:0] speedMultiplier;
  logic       timerDisplayEnable;
  logic       timerWaitEnable;
  logic       timeout;
  logic       timeoutDisplay;
  logic       timeoutWait;
  logic [3:0] time10s;
  logic [3:0] time1s;

  int total = 0;
  int bad   = 0;

  // Model: configured tens, and edges elapsed since each enable was first seen.
  int m_cfg, m_gk, m_dk, m_dn, m_wk;

  game_timer_control #(
    .CLK_HZ         (CLK_HZ),
    .WAIT_HALF_SECS (WAIT_HALF_SECS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ReConfig           (ReConfig),
    .incrementTime10    (incrementTime10),
    .decrementTime10    (decrementTime10),
    .timerEnable        (timerEnable),
    .speedMultiplier    (speedMultiplier),
    .timerDisplayEnable (timerDisplayEnable),
    .timerWaitEnable    (timerWaitEnable),
    .timeout            (timeout),
    .timeoutDisplay     (timeoutDisplay),
    .timeoutWait        (timeoutWait),
    .time10s            (time10s),
    .time1s             (time1s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_cfg = 0; m_gk = 0; m_dk = 0; m_dn = 1; m_wk = 0;
    end else begin
      if (ReConfig && !timerEnable && (incrementTime10 != decrementTime10)) begin
        if (incrementTime10 && m_cfg < 9) m_cfg++;
        if (decrementTime10 && m_cfg > 0) m_cfg--;
      end
      m_gk = timerEnable ? m_gk + 1 : 0;
      if (timerDisplayEnable) begin
        if (m_dk == 0) m_dn = (speedMultiplier == 2'd0) ? 1 : int'(speedMultiplier);
        m_dk++;
      end else begin
        m_dk = 0;
      end
      m_wk = timerWaitEnable ? m_wk + 1 : 0;
    end
  endtask

  task automatic check_model(input string tag);
    int t, rem;
    logic to, pd, pw;
    t   = m_cfg * 10 + 9;
    rem = t - m_gk / SEC;
    if (rem < 0) rem = 0;
    to = (m_gk > 0) && (rem == 0);
    pd = (m_dk > 0) && (m_dk == m_dn * HALF);
    pw = (m_wk > 0) && (m_wk == WAIT_HALF_SECS * HALF);
    chk({tag, ".t10"}, {4'd0, time10s}, 8'(rem / 10));
    chk({tag, ".t1"},  {4'd0, time1s},  8'(rem % 10));
    chk({tag, ".to"},  {7'd0, timeout}, {7'd0, to});
    chk({tag, ".pd"},  {7'd0, timeoutDisplay}, {7'd0, pd});
    chk({tag, ".pw"},  {7'd0, timeoutWait}, {7'd0, pw});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic strobe(input logic inc, input logic dec, input string tag);
    incrementTime10 = inc;
    decrementTime10 = dec;
    step(tag);
    incrementTime10 = 1'b0;
    decrementTime10 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ReConfig = 1'b0; incrementTime10 = 1'b0; decrementTime10 = 1'b0;
    timerEnable = 1'b0; speedMultiplier = 2'd0; timerDisplayEnable = 1'b0;
    timerWaitEnable = 1'b0;
    m_cfg = 0; m_gk = 0; m_dk = 0; m_dn = 1; m_wk = 0;

    // Reset and idle
    step("rst"); step("rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle");
    chk("idle_t10", {4'd0, time10s}, 8'd0);
    chk("idle_t1", {4'd0, time1s}, 8'd9);
    chk("idle_outs", {5'd0, timeout, timeoutDisplay, timeoutWait}, 8'd0);

    // Time edits
    ReConfig = 1'b1;
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, "inc");
    chk("inc3", {time10s, time1s}, 8'h39);
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, "inc");
    chk("inc10", {time10s, time1s}, 8'h99);
    strobe(1'b1, 1'b0, "inc_sat");
    chk("inc_sat", {time10s, time1s}, 8'h99);
    strobe(1'b1, 1'b1, "both");
    chk("both", {time10s, time1s}, 8'h99);
    for (int i = 0; i < 10; i++) strobe(1'b0, 1'b1, "dec");
    chk("dec10", {time10s, time1s}, 8'h09);
    strobe(1'b0, 1'b1, "dec_sat");
    chk("dec_sat", {time10s, time1s}, 8'h09);
    ReConfig = 1'b0;
    strobe(1'b1, 1'b0, "inc_noreconf");
    chk("inc_noreconf", {time10s, time1s}, 8'h09);

    // Countdown from 19 s
    ReConfig = 1'b1;
    strobe(1'b1, 1'b0, "cfg19");
    ReConfig = 1'b0;
    chk("cfg19", {time10s, time1s}, 8'h19);
    timerEnable = 1'b1;
    for (int c = 1; c <= 172; c++) begin
      step("cd");
      if (c == 7)   chk("cd_c7", {time10s, time1s}, 8'h19);
      if (c == 8)   chk("cd_c8", {time10s, time1s}, 8'h18);
      if (c == 151) chk("cd_c151", {time10s, time1s, 7'd0, timeout}, 16'h0100);
      if (c >= 152) chk("cd_expired", {time10s, time1s, 7'd0, timeout}, 16'h0001);
    end
    timerEnable = 1'b0;
    step("cd_drop");
    chk("cd_reload", {time10s, time1s, 7'd0, timeout}, 16'h1900);

    // Flash interval, speed 3 then speed 0
    speedMultiplier = 2'd3;
    timerDisplayEnable = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step("flash3");
      chk("flash3_pulse", {7'd0, timeoutDisplay}, {7'd0, c == 12});
      if (c == 5) speedMultiplier = 2'd1;
    end
    timerDisplayEnable = 1'b0;
    step("flash_off");
    speedMultiplier = 2'd0;
    timerDisplayEnable = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step("flash0");
      chk("flash0_pulse", {7'd0, timeoutDisplay}, {7'd0, c == 4});
    end
    timerDisplayEnable = 1'b0;
    step("flash_off");

    // Gap interval, plain and with a drop/re-raise
    timerWaitEnable = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step("gap");
      chk("gap_pulse", {7'd0, timeoutWait}, {7'd0, c == 4});
    end
    timerWaitEnable = 1'b0;
    step("gap_off");
    for (int c = 0; c < 12; c++) begin
      timerWaitEnable = (c != 2);
      step("gap_rearm");
      chk("gap_rearm_pulse", {7'd0, timeoutWait}, {7'd0, (c + 1) == 7});
    end
    timerWaitEnable = 1'b0;
    step("gap_off");

    // Reset mid-countdown with flash active
    timerEnable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (c == 45) begin
        speedMultiplier = 2'd3;
        timerDisplayEnable = 1'b1;
      end
      step("pre_rst");
    end
    rst = 1'b1;
    step("mid_rst");
    rst = 1'b0;
    chk("rst_time", {time10s, time1s, 7'd0, timeout}, 16'h0900);
    chk("rst_pulses", {6'd0, timeoutDisplay, timeoutWait}, 8'd0);
    for (int c = 1; c <= 8; c++) step("post_rst");
    chk("post_rst_dec", {time10s, time1s}, 8'h08);
    timerEnable = 1'b0;
    timerDisplayEnable = 1'b0;
    step("post_rst_drop");
    chk("post_rst_cfg", {time10s, time1s}, 8'h09);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst                = ($urandom_range(0, 299) == 0);
      ReConfig           = $urandom_range(0, 1) == 1;
      incrementTime10    = ($urandom_range(0, 3) == 0);
      decrementTime10    = ($urandom_range(0, 4) == 0);
      speedMultiplier    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) timerEnable = ~timerEnable;
      if ($urandom_range(0, 14) == 0)  timerDisplayEnable = ~timerDisplayEnable;
      if ($urandom_range(0, 9) == 0)   timerWaitEnable = ~timerWaitEnable;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_timer_control.md
# game_timer_control

Timekeeping stage directly downstream of the game state/score controller. It holds the player-configurable game time and counts it down while a game is active. It also runs the two one-shot interval timers that pace sequence flashing. It consumes the controller's timer-control strobes and enables, and returns the `timeout`, `timeoutDisplay` and `timeoutWait` events the controller's FSM waits on, plus BCD time digits for the 7-seg display stage.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: clock frequency. Derived values:
  - `SEC_CYCLES` = `CLK_HZ`
  - `HALF_CYCLES` = `CLK_HZ/2`
- `WAIT_HALF_SECS`, default 1: length of the blank gap between flashes, in half-seconds.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `ReConfig` in 1: time-edit mode.
- `incrementTime10` in 1: one-cycle strobe, add 10 s.
- `decrementTime10` in 1: one-cycle strobe, subtract 10 s.
- `timerEnable` in 1: game countdown runs while high.
- `speedMultiplier` in 2: flash length in half-seconds. 3 = 1.5 s, 2 = 1.0 s, 1 = 0.5 s, 0 is treated as 1.
- `timerDisplayEnable` in 1: arms the flash interval.
- `timerWaitEnable` in 1: arms the gap interval.
- `timeout` out 1: level; game time exhausted.
- `timeoutDisplay` out 1: one-cycle pulse; flash interval elapsed.
- `timeoutWait` out 1: one-cycle pulse; gap interval elapsed.
- `time10s` out 4: BCD tens digit of the shown time.
- `time1s` out 4: BCD ones digit of the shown time.

## Operation
- **Configured time:** `cfg10s`, range 0..9. The configured value is `cfg10s`:9, so 09..99 s.
  - Reset value is 0, giving 09 s.
- **Time edits:** accepted only when `ReConfig`=1 and `timerEnable`=0.
  - Increment applies if `cfg10s`<9; otherwise ignored.
  - Decrement applies if `cfg10s`>0; otherwise ignored.
  - Increment and decrement in the same cycle: both ignored.
- **Game countdown FSM:** states IDLE, RUN, EXPIRED.
  - IDLE (`timerEnable`=0):
    - Shown time = `cfg10s`:9.
    - Second prescaler held at 0.
    - `timeout`=0.
  - IDLE→RUN on the first cycle `timerEnable`=1.
  - RUN: every `SEC_CYCLES` cycles, decrement the shown time in BCD. When ones is 0, ones→9 and tens−1.
  - RUN→EXPIRED on the same edge the shown time becomes 00. `timeout` goes 1 on that edge.
  - EXPIRED: time holds 00 and `timeout` stays 1.
  - Any state → IDLE when `timerEnable`=0. The shown time reloads from config and `timeout` clears.
- **Flash interval** (`timerDisplayEnable`):
  - When enable is first seen high, latch `speedMultiplier` (0→1) and start a cycle counter from 0.
  - Emit one `timeoutDisplay` pulse after mult×`HALF_CYCLES` cycles, then stop (DONE) while enable stays high.
  - Enable low clears the counter and DONE. A new rising enable restarts the interval.
  - Changes to `speedMultiplier` mid-interval are ignored.
- **Gap interval** (`timerWaitEnable`): same behaviour, fixed length `WAIT_HALF_SECS`×`HALF_CYCLES`, pulsing `timeoutWait`.
- **Independence:** all three timers run concurrently and independently.
- **Reset:** `rst` has priority over every input and aborts any running interval or countdown.
- **Reset values:**
  - `timeout`=0, `timeoutDisplay`=0, `timeoutWait`=0.
  - `time10s`=0, `time1s`=9.
  - `cfg10s`=0, all counters 0, FSM=IDLE.

## Timing
- All outputs are registered. No combinational path from input to output.
- Edit strobe in cycle t → updated `time10s` visible from cycle t+1.
- Countdown: `timerEnable` first high in cycle 0 → first decrement visible in cycle `SEC_CYCLES`.
  - 00 and `timeout`=1 are visible in cycle T×`SEC_CYCLES`, where T = configured seconds.
- Interval: enable first high in cycle 0 → pulse high in exactly cycle N×`HALF_CYCLES` (N = number of half-seconds), low in the next cycle.
- Enable dropped before the pulse cycle → no pulse. Enable dropped in the pulse cycle → pulse still emitted.
- `timerEnable` low in cycle t → reload and `timeout`=0 visible in cycle t+1.

## Structure
- **Shared package** `game_timer_pkg`:
  - BCD digit typedef (4 bits).
  - `DEFAULT_CFG10S`=0, `MAX_CFG10S`=9.
  - Speed-to-half-second mapping constant.
  - Countdown FSM state enum.
- **Sub-module** `halfsec_interval`: one-shot interval counter.
  - Inputs: `clk`, `rst`, `enable`, `halfsecs[1:0]`. Output: `done_pulse`.
  - Parameter: `HALF_CYCLES`.
  - Instantiated twice: once for flash, once for gap.

## Test plan
All cases use `CLK_HZ`=8, so `SEC_CYCLES`=8 and `HALF_CYCLES`=4.
1. Reset, then idle 5 cycles → `time10s`=0, `time1s`=9, `timeout`=`timeoutDisplay`=`timeoutWait`=0.
2. `ReConfig`=1; increment ×3 → 3:9. Then:
   - Increment ×7 → 9:9; an 8th increment stays 9:9.
   - Increment and decrement strobed together → no change.
   - Decrement ×10 → 0:9 and stays 0:9.
   - Increment with `ReConfig`=0 → ignored.
3. Config 1:9, then `timerEnable`=1 at cycle 0:
   - Cycle 8 → 1:8. Cycle 152 → 0:0 and `timeout`=1, held 20 more cycles.
   - Drop enable → next cycle 1:9 with `timeout`=0.
4. `speedMultiplier`=3, `timerDisplayEnable` rises at cycle 0 → single `timeoutDisplay` pulse at cycle 12 and none after while held. Repeat with `speedMultiplier`=0 → pulse at cycle 4.
5. `timerWaitEnable` rises at cycle 0 → pulse at cycle 4. Drop at cycle 2 and re-raise at cycle 3 → no pulse at cycle 4, pulse at cycle 7.
6. `rst` at cycle 50 of a countdown with flash interval active → next cycle 0:9, `cfg10s`=0, no pulses, `timeout`=0. Countdown restarts only when `timerEnable` is re-seen high.
